// File: rtl/lap_counter_bcd.sv
// Lap counter holding the count as packed BCD digits, with a mark synchroniser, edge detection,
// wrap/saturate at all-9s and sticky target detection. Define LAP_HOLDOFF_EN to compile in re-trigger holdoff.
module lap_counter_bcd #(
    parameter int unsigned DIGITS         = 2,
    parameter bit          WRAP           = 1'b1,
    parameter int unsigned HOLDOFF_CYCLES = 1000
) (
    input  logic                  tact,
    input  logic                  reset,
    input  logic                  lap_mark,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  lap_pulse,
    output logic                  done,
    output logic                  overflow
);

    if (DIGITS < 1 || DIGITS > 8 || HOLDOFF_CYCLES < 1) begin : g_bad_params
        $error("lap_counter_bcd: parameter out of range");
    end

    logic                sync1;
    logic                sync2;
    logic                prev;
    logic                rise;
    logic                accept;
    logic                holdoff_active;
    logic                all_nines;
    logic [4*DIGITS-1:0] inc;
    logic [4*DIGITS-1:0] count_next;
    logic                done_next;

    always_ff @(posedge tact or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= lap_mark;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

`ifdef LAP_HOLDOFF_EN
    localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt;

    assign holdoff_active = (hold_cnt != '0);

    always_ff @(posedge tact or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (clear) begin
            hold_cnt <= '0;
        end else if (accept) begin
            hold_cnt <= HOLD_W'(HOLDOFF_CYCLES);
        end else if (holdoff_active) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end
`else
    assign holdoff_active = 1'b0;
`endif

    assign accept = rise & ~done & ~holdoff_active & ~clear;

    // Ripple carry: a digit advances only when every lower digit is 9.
    always_comb begin
        logic       carry;
        logic [3:0] nib;
        inc   = digits;
        carry = 1'b1;
        nib   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = digits[4*i +: 4];
            if (carry) begin
                inc[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
            end
            carry = carry & (nib == 4'd9);
        end
        all_nines = carry;
    end

    always_comb begin
        count_next = digits;
        if (accept && !(all_nines && !WRAP)) begin
            count_next = inc;
        end
        done_next = done | ((target != '0) && (count_next == target));
    end

    always_ff @(posedge tact or negedge reset) begin
        if (!reset) begin
            digits    <= '0;
            lap_pulse <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            digits    <= '0;
            lap_pulse <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            digits    <= count_next;
            lap_pulse <= accept;
            done      <= done_next;
            overflow  <= accept & all_nines;
        end
    end

endmodule
